// File: rtl/pt8211_tx_if.sv
// Sample-pair handshake between a producer and the PT8211 transmitter.
// The producer holds s_left/s_right stable while s_valid is high until s_ready.
interface pt8211_tx_if #(
  parameter int DATA_W = 16
) ();
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;

  modport master (
    output s_valid,
    output s_left,
    output s_right,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_left,
    input  s_right,
    output s_ready
  );
endinterface

// File: rtl/pt8211_tx.sv
// PT8211 stereo DAC serialiser: BCK/WS/DIN generation, one-pair holding register.
// Build option PT8211_UNDERRUN_MUTE_EN: underrun frames send zeros instead of the last pair.
module pt8211_tx #(
  parameter int CLK_PER_HALF_BCK = 2,
  parameter int DATA_W           = 16
) (
  input  logic        clk,
  input  logic        rst,
  pt8211_tx_if.slave  s_if,
  output logic        bck,
  output logic        ws,
  output logic        din,
  output logic        frame_start,
  output logic        underrun
);

  localparam int FRAME_BITS = 2 * DATA_W;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = (CLK_PER_HALF_BCK > 1) ? $clog2(CLK_PER_HALF_BCK) : 1;
  localparam logic [DIV_W-1:0] DIV_TC  = DIV_W'(CLK_PER_HALF_BCK - 1);
  localparam logic [BIT_W-1:0] BIT_TC  = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] WS_EDGE = BIT_W'(DATA_W);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t                state;
  state_t                state_nxt;

  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BIT_W-1:0]      bit_nxt;
  logic [FRAME_BITS-1:0] shifter;

  logic                  hold_full;
  logic [DATA_W-1:0]     hold_l;
  logic [DATA_W-1:0]     hold_r;

  logic                  div_tc;
  logic                  bck_fall;
  logic                  frame_wrap;
  logic                  load_now;
  logic                  accept;
  logic [DATA_W-1:0]     fill_l;
  logic [DATA_W-1:0]     fill_r;

`ifndef PT8211_UNDERRUN_MUTE_EN
  logic [DATA_W-1:0]     last_l;
  logic [DATA_W-1:0]     last_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    div_tc     = (div_cnt == DIV_TC);
    bck_fall   = (state == ST_RUN) && div_tc && bck;
    frame_wrap = bck_fall && (bit_cnt == BIT_TC);
    bit_nxt    = bit_cnt + 1'b1;
    load_now   = ((state == ST_IDLE) && hold_full) || frame_wrap;
    s_if.s_ready = !hold_full || load_now;
    accept     = s_if.s_valid && s_if.s_ready;

    if ((state == ST_IDLE) && hold_full) begin
      state_nxt = ST_RUN;
    end

    // A frame with nothing held repeats the previous pair, or goes silent when muted.
    if (hold_full) begin
      fill_l = hold_l;
      fill_r = hold_r;
    end else begin
`ifdef PT8211_UNDERRUN_MUTE_EN
      fill_l = '0;
      fill_r = '0;
`else
      fill_l = last_l;
      fill_r = last_r;
`endif
    end
  end

  // The holding register may refill in the same edge the shifter drains it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_l    <= s_if.s_left;
      hold_r    <= s_if.s_right;
    end else if (load_now) begin
      hold_full <= 1'b0;
    end
  end

`ifndef PT8211_UNDERRUN_MUTE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_l <= '0;
      last_r <= '0;
    end else if (load_now && hold_full) begin
      last_l <= hold_l;
      last_r <= hold_r;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      shifter     <= '0;
      bck         <= 1'b0;
      ws          <= 1'b0;
      din         <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (load_now) begin
        shifter     <= {fill_l, fill_r};
        din         <= fill_l[DATA_W-1];
        ws          <= 1'b0;
        bit_cnt     <= '0;
        div_cnt     <= '0;
        bck         <= 1'b0;
        frame_start <= 1'b1;
        underrun    <= !hold_full;
      end else if (state == ST_RUN) begin
        if (div_tc) begin
          div_cnt <= '0;
          bck     <= !bck;
          // ws flips together with the new channel's MSB on the same falling edge.
          if (bck_fall) begin
            bit_cnt <= bit_nxt;
            shifter <= {shifter[FRAME_BITS-2:0], 1'b0};
            din     <= shifter[FRAME_BITS-2];
            ws      <= (bit_nxt >= WS_EDGE);
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule
